rgb2gray_stream: RTL and testbench

//  Streaming, pipelined RGB-to-luma converter for the image path; next generation of the combinational weighted-sum converter.

---
 rtl/rgb_pkg.sv | 19 +
 rtl/rgb2gray_stream_if.sv | 35 +++
 rtl/rgb_wsum_pipe.sv | 72 +++++++
 rtl/rgb2gray_stream.sv | 160 ++++++++++++++++
 tb/tb_rgb2gray_stream.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the streaming RGB-to-luma converter:
// default widths, default BT.601-style weights and output modes.
package rgb_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int COEF_W_DEF = 7;

  localparam int COEF_R_DEF = 38;
  localparam int COEF_G_DEF = 75;
  localparam int COEF_B_DEF = 15;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_BIN  = 2'd1,
    MODE_RAW  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

endpackage

// File: rtl/rgb2gray_stream_if.sv
// Pixel-in / result-out valid-ready bundle of the converter.
// The slave view is the converter, the master view its neighbours.
interface rgb2gray_stream_if
  import rgb_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int SUM_W = PIX_W_DEF + COEF_W_DEF + 2
);

  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_red;
  logic [PIX_W-1:0] s_green;
  logic [PIX_W-1:0] s_blue;

  logic             m_valid;
  logic             m_ready;
  logic [SUM_W-1:0] m_data;
  logic             m_last;

  modport master (
    output s_valid, s_red, s_green, s_blue,
    output m_ready,
    input  s_ready,
    input  m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_red, s_green, s_blue,
    input  m_ready,
    output s_ready,
    output m_valid, m_data, m_last
  );

endinterface

// File: rtl/rgb_wsum_pipe.sv
// Two-stage weighted-sum pipe: products, then their sum.
// Valid and an opaque tag travel alongside under the shared enable.
module rgb_wsum_pipe
  import rgb_pkg::*;
#(
  parameter  int PIX_W  = PIX_W_DEF,
  parameter  int COEF_W = COEF_W_DEF,
  parameter  int TAG_W  = 1,
  localparam int PROD_W = PIX_W + COEF_W,
  localparam int SUM_W  = PIX_W + COEF_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [PIX_W-1:0]  i_red,
  input  logic [PIX_W-1:0]  i_green,
  input  logic [PIX_W-1:0]  i_blue,
  input  logic [COEF_W-1:0] i_coef_r,
  input  logic [COEF_W-1:0] i_coef_g,
  input  logic [COEF_W-1:0] i_coef_b,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  output logic [SUM_W-1:0]  o_sum,
  output logic [TAG_W-1:0]  o_tag
);

  logic              r_v1;
  logic [PROD_W-1:0] r_pr;
  logic [PROD_W-1:0] r_pg;
  logic [PROD_W-1:0] r_pb;
  logic [TAG_W-1:0]  r_tag1;

  logic              r_v2;
  logic [SUM_W-1:0]  r_sum;
  logic [TAG_W-1:0]  r_tag2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_pr   <= '0;
      r_pg   <= '0;
      r_pb   <= '0;
      r_tag1 <= '0;
    end else if (i_en) begin
      r_v1   <= i_valid;
      r_pr   <= PROD_W'(i_red)   * PROD_W'(i_coef_r);
      r_pg   <= PROD_W'(i_green) * PROD_W'(i_coef_g);
      r_pb   <= PROD_W'(i_blue)  * PROD_W'(i_coef_b);
      r_tag1 <= i_tag;
    end
  end

  // Two guard bits keep the three-term sum exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_sum  <= '0;
      r_tag2 <= '0;
    end else if (i_en) begin
      r_v2   <= r_v1;
      r_sum  <= SUM_W'(r_pr) + SUM_W'(r_pg)
              + SUM_W'(r_pb);
      r_tag2 <= r_tag1;
    end
  end

  assign o_valid = r_v2;
  assign o_sum   = r_sum;
  assign o_tag   = r_tag2;

endmodule

// File: rtl/rgb2gray_stream.sv
// Streaming RGB-to-luma converter: handshake, frame tracking,
// frame-atomic config shadows and the output mode stage.
module rgb2gray_stream
  import rgb_pkg::*;
#(
  parameter  int PIX_W        = PIX_W_DEF,
  parameter  int COEF_W       = COEF_W_DEF,
  parameter  int FRAME_PIXELS = 16384,
  parameter  int FCNT_W       = 16,
  localparam int SUM_W        = PIX_W + COEF_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cfg_mode,
  input  logic [PIX_W-1:0]  cfg_threshold,
  input  logic [COEF_W-1:0] cfg_coef_r,
  input  logic [COEF_W-1:0] cfg_coef_g,
  input  logic [COEF_W-1:0] cfg_coef_b,
  rgb2gray_stream_if.slave  bus,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int CNT_W =
    (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(FRAME_PIXELS - 1);
  localparam int ADD_W = SUM_W + 1;
  localparam logic [ADD_W-1:0] HALF =
    ADD_W'(1) << (COEF_W - 1);
  localparam logic [ADD_W-1:0] SAT =
    ADD_W'((1 << PIX_W) - 1);

  typedef struct packed {
    logic             last;
    mode_e            mode;
    logic [PIX_W-1:0] thr;
  } tag_t;

  logic              w_en;
  logic              w_in_fire;
  logic              w_first;
  logic [COEF_W-1:0] w_cr;
  logic [COEF_W-1:0] w_cg;
  logic [COEF_W-1:0] w_cb;
  tag_t              w_tag_in;
  tag_t              w_tag2;
  logic              w_v2;
  logic [SUM_W-1:0]  w_sum2;
  logic [ADD_W-1:0]  w_shift;
  logic [PIX_W-1:0]  w_gray;
  logic [SUM_W-1:0]  w_res;

  logic [CNT_W-1:0]  r_pix;
  logic [COEF_W-1:0] r_sh_cr;
  logic [COEF_W-1:0] r_sh_cg;
  logic [COEF_W-1:0] r_sh_cb;
  mode_e             r_sh_mode;
  logic [PIX_W-1:0]  r_sh_thr;
  logic              r_v3;
  logic [SUM_W-1:0]  r_data;
  logic              r_last;
  logic [FCNT_W-1:0] r_fcnt;

  assign w_en        = !r_v3 || bus.m_ready;
  assign bus.s_ready = w_en;
  assign w_in_fire   = bus.s_valid && w_en;
  assign w_first     = (r_pix == '0);

  // Pixel 0 sees live config; the rest of the frame sees its copy.
  assign w_cr = w_first ? cfg_coef_r : r_sh_cr;
  assign w_cg = w_first ? cfg_coef_g : r_sh_cg;
  assign w_cb = w_first ? cfg_coef_b : r_sh_cb;

  always_comb begin
    w_tag_in.last = (r_pix == LAST_IDX);
    w_tag_in.mode = w_first ? mode_e'(cfg_mode) : r_sh_mode;
    w_tag_in.thr  = w_first ? cfg_threshold : r_sh_thr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix     <= '0;
      r_sh_cr   <= COEF_W'(COEF_R_DEF);
      r_sh_cg   <= COEF_W'(COEF_G_DEF);
      r_sh_cb   <= COEF_W'(COEF_B_DEF);
      r_sh_mode <= MODE_GRAY;
      r_sh_thr  <= '0;
    end else if (w_in_fire) begin
      r_pix <= (r_pix == LAST_IDX) ? '0 : r_pix + 1'b1;
      if (w_first) begin
        r_sh_cr   <= cfg_coef_r;
        r_sh_cg   <= cfg_coef_g;
        r_sh_cb   <= cfg_coef_b;
        r_sh_mode <= mode_e'(cfg_mode);
        r_sh_thr  <= cfg_threshold;
      end
    end
  end

  rgb_wsum_pipe #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .TAG_W  ($bits(tag_t))
  ) u_wsum (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_en),
    .i_valid  (w_in_fire),
    .i_red    (bus.s_red),
    .i_green  (bus.s_green),
    .i_blue   (bus.s_blue),
    .i_coef_r (w_cr),
    .i_coef_g (w_cg),
    .i_coef_b (w_cb),
    .i_tag    (w_tag_in),
    .o_valid  (w_v2),
    .o_sum    (w_sum2),
    .o_tag    (w_tag2)
  );

  always_comb begin
    w_shift = ({1'b0, w_sum2} + HALF) >> COEF_W;
    w_gray  = (w_shift > SAT) ? '1 : w_shift[PIX_W-1:0];
    w_res   = '0;
    unique case (1'b1)
      (w_tag2.mode == MODE_BIN):
        w_res = (w_gray >= w_tag2.thr) ? SUM_W'(SAT) : '0;
      (w_tag2.mode == MODE_RAW):
        w_res = w_sum2;
      default:
        w_res = SUM_W'(w_gray);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3   <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_en) begin
      r_v3   <= w_v2;
      r_data <= w_res;
      r_last <= w_v2 && w_tag2.last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= '0;
    end else if (r_v3 && bus.m_ready && r_last) begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign bus.m_valid = r_v3;
  assign bus.m_data  = r_data;
  assign bus.m_last  = r_last;
  assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Bench for rgb2gray_stream: directed pixels plus random frames
// checked against a frame-level behavioural model.
module tb_rgb2gray_stream;
  import rgb_pkg::*;

  localparam int PW = 8;
  localparam int CW = 7;
  localparam int FP = 16384;
  localparam int FW = 16;
  localparam int SW = PW + CW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_threshold;
  logic [CW-1:0] cfg_coef_r;
  logic [CW-1:0] cfg_coef_g;
  logic [CW-1:0] cfg_coef_b;
  logic [FW-1:0] frame_cnt;

  rgb2gray_stream_if #(.PIX_W(PW), .SUM_W(SW)) bus ();

  rgb2gray_stream #(
    .PIX_W        (PW),
    .COEF_W       (CW),
    .FRAME_PIXELS (FP),
    .FCNT_W       (FW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_mode      (cfg_mode),
    .cfg_threshold (cfg_threshold),
    .cfg_coef_r    (cfg_coef_r),
    .cfg_coef_g    (cfg_coef_g),
    .cfg_coef_b    (cfg_coef_b),
    .bus           (bus),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   m_idx, m_frames;
  int   mc_r, mc_g, mc_b, mc_mode, mc_thr;
  int   out_cnt, last_cnt, last_pos, nonbin;
  int   chg_at = -1;
  bit   held_v;
  logic [SW-1:0] held_d;
  logic held_l;

  task automatic chk(string nm, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Luma from plain integer arithmetic: round(sum/128), clamp 255.
  function automatic int model(int r, int g, int b, int cr,
                               int cg, int cb, int md, int th);
    int s;
    int gy;
    s  = r * cr + g * cg + b * cb;
    gy = (s + 64) / 128;
    if (gy > 255) gy = 255;
    if (md == 1) return (gy >= th) ? 255 : 0;
    if (md == 2) return s;
    return gy;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_idx    = 0;
      m_frames = 0;
      held_v   = 0;
      out_cnt  = 0;
      last_cnt = 0;
      last_pos = -1;
      nonbin   = 0;
    end else begin
      chk("s_ready", bus.s_ready, !bus.m_valid || bus.m_ready);
      chk("frame_cnt", frame_cnt, m_frames % 65536);
      if (held_v) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, held_d);
        chk("hold_last", bus.m_last, held_l);
      end
      if (bus.s_valid && bus.s_ready) begin
        if (m_idx == 0) begin
          mc_r = cfg_coef_r; mc_g = cfg_coef_g; mc_b = cfg_coef_b;
          mc_mode = cfg_mode; mc_thr = cfg_threshold;
        end
        e.data = model(bus.s_red, bus.s_green, bus.s_blue,
                       mc_r, mc_g, mc_b, mc_mode, mc_thr);
        e.last = (m_idx == FP - 1);
        m_idx  = (m_idx + 1) % FP;
        exp_q.push_back(e);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_output: got data %0d, expected none",
                   bus.m_data);
        end else begin
          e = exp_q.pop_front();
          chk("data", bus.m_data, e.data);
          chk("last", bus.m_last, e.last);
          if (e.last) m_frames++;
        end
        if (bus.m_last) begin
          last_cnt++;
          last_pos = out_cnt;
        end
        if (out_cnt >= FP && bus.m_data != 0 && bus.m_data != 255)
          nonbin++;
        out_cnt++;
      end
      held_v = bus.m_valid && !bus.m_ready;
      held_d = bus.m_data;
      held_l = bus.m_last;
    end
  end

  task automatic cfg_default();
    cfg_mode      = 2'd0;
    cfg_threshold = '0;
    cfg_coef_r    = 7'(COEF_R_DEF);
    cfg_coef_g    = 7'(COEF_G_DEF);
    cfg_coef_b    = 7'(COEF_B_DEF);
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_s_ready", bus.s_ready, 1);
  endtask

  task automatic one(string nm, int r, int g, int b, int cr,
                     int cg, int cb, int md, int th, int expv);
    int lat;
    do_reset();
    cfg_coef_r    = 7'(cr);
    cfg_coef_g    = 7'(cg);
    cfg_coef_b    = 7'(cb);
    cfg_mode      = 2'(md);
    cfg_threshold = 8'(th);
    bus.s_red   = 8'(r);
    bus.s_green = 8'(g);
    bus.s_blue  = 8'(b);
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
    lat = 1;
    while (!bus.m_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({nm, "_latency"}, lat, 3);
    chk(nm, bus.m_data, expv);
    @(posedge clk);
    #1 cfg_default();
  endtask

  task automatic stream(int n, int vpct, int rpct);
    int  sent = 0;
    int  cyc = 0;
    bit  acc;
    bus.s_valid = 1'b0;
    while (sent < n) begin
      if (cyc > n * 4 + 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_timeout: sent %0d, expected %0d",
                 sent, n);
        break;
      end
      cyc++;
      if (chg_at >= 0 && sent == chg_at) begin
        cfg_mode      = 2'd1;
        cfg_threshold = 8'($urandom);
        cfg_coef_r    = 7'($urandom);
      end
      if (!bus.s_valid && $urandom_range(99) < vpct) begin
        bus.s_valid = 1'b1;
        bus.s_red   = 8'($urandom);
        bus.s_green = 8'($urandom);
        bus.s_blue  = 8'($urandom);
      end
      bus.m_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        bus.s_valid = 1'b0;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.m_valid) && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int acc4;
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    bus.s_red   = '0;
    bus.s_green = '0;
    bus.s_blue  = '0;
    cfg_default();
    #2;

    one("white_gray", 255, 255, 255, 38, 75, 15, 0, 0, 255);
    one("white_raw", 255, 255, 255, 38, 75, 15, 2, 0, 32640);
    one("red_gray", 255, 0, 0, 38, 75, 15, 0, 0, 76);
    one("red_raw", 255, 0, 0, 38, 75, 15, 2, 0, 9690);
    one("red_bin128", 255, 0, 0, 38, 75, 15, 1, 128, 0);
    one("red_bin76", 255, 0, 0, 38, 75, 15, 1, 76, 255);
    one("red_rsvd", 255, 0, 0, 38, 75, 15, 3, 0, 76);
    one("sat_gray", 255, 255, 255, 127, 127, 127, 0, 0, 255);
    one("sat_raw", 255, 255, 255, 127, 127, 127, 2, 0, 97155);

    // Continuous stream with a 5-cycle downstream stall.
    do_reset();
    acc4 = 0;
    for (int c = 0; c < 30; c++) begin
      if (!bus.s_valid || bus.s_ready) begin
        bus.s_red   = 8'($urandom);
        bus.s_green = 8'($urandom);
        bus.s_blue  = 8'($urandom);
      end
      bus.s_valid = 1'b1;
      bus.m_ready = !(c >= 10 && c < 15);
      @(negedge clk);
      if (c == 10) begin
        chk("bp_full_valid", bus.m_valid, 1);
        chk("bp_s_ready_low", bus.s_ready, 0);
      end
      if (bus.s_ready) acc4++;
      @(posedge clk);
      #1;
    end
    drain();
    chk("bp_no_loss", out_cnt, acc4);

    // Full frame, mode switched to binary mid-frame.
    do_reset();
    cfg_threshold = 8'd100;
    chg_at = 100;
    stream(FP + 64, 90, 90);
    chg_at = -1;
    drain();
    chk("f_out_count", out_cnt, FP + 64);
    chk("f_last_count", last_cnt, 1);
    chk("f_last_pos", last_pos, FP - 1);
    chk("f_frame_cnt", frame_cnt, 1);
    chk("f2_binary", nonbin, 0);

    // Reset with the pipe full, then a fresh frame.
    cfg_default();
    cfg_coef_r = 7'($urandom);
    cfg_coef_g = 7'($urandom);
    cfg_coef_b = 7'($urandom);
    do_reset();
    stream(5000, 100, 100);
    chk("rst_inflight", bus.m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    stream(FP, 95, 95);
    drain();
    chk("r_last_count", last_cnt, 1);
    chk("r_last_pos", last_pos, FP - 1);
    chk("r_frame_cnt", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
